// File: rtl/mlp_pkg.sv
// Shared types and constants for the MLP feeder: buffered pair layout, sequencer
// state encoding and the neuron accumulator width.
package mlp_pkg;

  localparam int MLP_ACC_W = 16;

  typedef struct packed {
    logic [3:0] w;
    logic [3:0] i;
  } pair_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_STREAM,
    ST_CAPTURE,
    ST_OUT_LO,
    ST_OUT_HI
  } feeder_state_t;

endpackage

// File: rtl/mlp_pair_buf.sv
// DEPTH x 8 pair storage: one synchronous write port, one combinational read port.
// Contents are deliberately not reset; validity is tracked by the feeder's count.
module mlp_pair_buf
  import mlp_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  pair_t         i_wdata,
  input  logic [AW-1:0] i_raddr,
  output pair_t         o_rdata
);

  pair_t r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/mlp_feeder.sv
// Producer-side sequencer for the MAC/ReLU neuron: buffers (input, weight) pairs,
// streams them into the accumulator on start, and returns the 16-bit result bytewise.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_IDLE    | accept pair loads, wait for start
// ST_CLEAR   | one cycle, zero the accumulator and rewind the read pointer
// ST_STREAM  | one buffered pair per cycle into the accumulator
// ST_CAPTURE | one cycle, latch the ReLU result
// ST_OUT_LO  | offer result[7:0] until taken
// ST_OUT_HI  | offer result[15:8]; on handshake empty the buffer
module mlp_feeder
  import mlp_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_valid,
  input  logic [7:0]           load_data,
  output logic                 load_ready,
  input  logic                 start,
  output logic                 busy,
  output logic [AW:0]          count,
  output logic                 mac_clear,
  output logic                 mac_valid,
  output logic [3:0]           mac_i,
  output logic [3:0]           mac_w,
  input  logic [MLP_ACC_W-1:0] mac_relu,
  output logic                 res_valid,
  output logic [7:0]           res_byte,
  input  logic                 res_ready
);

  localparam logic [AW:0]   CNT_ONE = 1;
  localparam logic [AW-1:0] PTR_ONE = 1;

  feeder_state_t        r_state;
  logic [AW:0]          r_count;
  logic [AW-1:0]        r_rd_ptr;
  logic [MLP_ACC_W-1:0] r_result;

  logic  w_accept;
  logic  w_last;
  pair_t w_rd_pair;

  // count[AW] set means all DEPTH slots are occupied
  assign w_accept = (r_state == ST_IDLE) && load_valid && !r_count[AW];
  assign w_last   = ({1'b0, r_rd_ptr} == (r_count - CNT_ONE));

  mlp_pair_buf #(.DEPTH(DEPTH)) u_buf (
    .clk     (clk),
    .i_we    (w_accept),
    .i_waddr (r_count[AW-1:0]),
    .i_wdata (pair_t'(load_data)),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rd_pair)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) r_count <= r_count + CNT_ONE;
          if (start)    r_state <= ST_CLEAR;
        end
        ST_CLEAR: begin
          r_rd_ptr <= '0;
          r_state  <= (r_count != '0) ? ST_STREAM : ST_CAPTURE;
        end
        ST_STREAM: begin
          // hold the pointer on the last pair so it never passes count-1
          if (w_last) r_state  <= ST_CAPTURE;
          else        r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
        ST_CAPTURE: begin
          r_result <= mac_relu;
          r_state  <= ST_OUT_LO;
        end
        ST_OUT_LO: begin
          if (res_ready) r_state <= ST_OUT_HI;
        end
        ST_OUT_HI: begin
          if (res_ready) begin
            r_count <= '0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy       = (r_state != ST_IDLE);
  assign load_ready = (r_state == ST_IDLE) && !r_count[AW];
  assign count      = r_count;
  assign mac_clear  = (r_state == ST_CLEAR);
  assign mac_valid  = (r_state == ST_STREAM);
  assign mac_i      = mac_valid ? w_rd_pair.i : 4'd0;
  assign mac_w      = mac_valid ? w_rd_pair.w : 4'd0;
  assign res_valid  = (r_state == ST_OUT_LO) || (r_state == ST_OUT_HI);

  always_comb begin
    res_byte = 8'd0;
    if (r_state == ST_OUT_LO)      res_byte = r_result[7:0];
    else if (r_state == ST_OUT_HI) res_byte = r_result[15:8];
  end

endmodule

// File: tb/tb_mlp_feeder.sv
// Bench for mlp_feeder: behavioural accumulator on the MAC side, a run-timeline
// reference model with a per-cycle compare, directed literal cases and random runs.
module tb_mlp_feeder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_valid = 1'b0;
  logic [7:0]  load_data = 8'd0;
  logic        load_ready;
  logic        start = 1'b0;
  logic        busy;
  logic [4:0]  count;
  logic        mac_clear;
  logic        mac_valid;
  logic [3:0]  mac_i;
  logic [3:0]  mac_w;
  logic [15:0] mac_relu;
  logic        res_valid;
  logic [7:0]  res_byte;
  logic        res_ready = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mlp_feeder #(.DEPTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .start      (start),
    .busy       (busy),
    .count      (count),
    .mac_clear  (mac_clear),
    .mac_valid  (mac_valid),
    .mac_i      (mac_i),
    .mac_w      (mac_w),
    .mac_relu   (mac_relu),
    .res_valid  (res_valid),
    .res_byte   (res_byte),
    .res_ready  (res_ready)
  );

  function automatic int sx4(input logic [3:0] v);
    return v[3] ? int'(v) - 16 : int'(v);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  // Neuron accumulator owned by the environment
  int acc = 0;
  int n_valid = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc <= 0;
    else if (mac_clear) acc <= 0;
    else if (mac_valid) begin
      acc     <= acc + sx4(mac_i) * sx4(mac_w);
      n_valid <= n_valid + 1;
    end
  end
  assign mac_relu = (acc < 0) ? 16'd0 : 16'(acc);

  // Reference model: a run is a timeline counted in cycles since start
  int          m_run = 0;
  int          m_cyc = 0;
  int          m_n = 0;
  int          m_hi = 0;
  logic [7:0]  m_q[$];
  logic [15:0] m_res = 16'd0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_run = 0; m_cyc = 0; m_hi = 0;
        m_q.delete();
      end else if (m_run == 0) begin
        if (load_valid && m_q.size() < 16) m_q.push_back(load_data);
        if (start) begin
          int s;
          s = 0;
          foreach (m_q[k]) begin
            logic [7:0] p;
            p = m_q[k];
            s += sx4(p[3:0]) * sx4(p[7:4]);
          end
          m_res = (s < 0) ? 16'd0 : 16'(s);
          m_n   = m_q.size();
          m_run = 1;
          m_cyc = 1;
        end
      end else if (m_cyc < m_n + 3) begin
        m_cyc++;
      end else if (res_ready) begin
        if (m_hi != 0) begin
          m_run = 0; m_hi = 0;
          m_q.delete();
        end else begin
          m_hi = 1;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      begin
        int e_cnt, e_lr, e_clr, e_val, e_i, e_w, e_rv, e_rb;
        logic [7:0] p;
        e_cnt = (m_run != 0) ? m_n : m_q.size();
        e_lr  = (m_run == 0 && m_q.size() < 16) ? 1 : 0;
        e_clr = (m_run != 0 && m_cyc == 1) ? 1 : 0;
        e_val = (m_run != 0 && m_cyc >= 2 && m_cyc <= m_n + 1) ? 1 : 0;
        e_i = 0; e_w = 0;
        if (e_val != 0) begin
          p = m_q[m_cyc - 2];
          e_i = int'(p[3:0]);
          e_w = int'(p[7:4]);
        end
        e_rv = (m_run != 0 && m_cyc >= m_n + 3) ? 1 : 0;
        e_rb = 0;
        if (e_rv != 0) e_rb = (m_hi != 0) ? int'(m_res[15:8]) : int'(m_res[7:0]);
        chk("busy", busy, (m_run != 0) ? 1 : 0);
        chk("load_ready", load_ready, e_lr);
        chk("count", count, e_cnt);
        chk("mac_clear", mac_clear, e_clr);
        chk("mac_valid", mac_valid, e_val);
        chk("mac_i", mac_i, e_i);
        chk("mac_w", mac_w, e_w);
        chk("res_valid", res_valid, e_rv);
        chk("res_byte", res_byte, e_rb);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] d);
    load_valid = 1'b1;
    load_data  = d;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Wait for the result, optionally stall in OUT_LO, then take both bytes
  task automatic run_expect(input string tag, input logic [15:0] exp, input int stall);
    int b;
    b = 0;
    while (!res_valid && b < 200) begin
      tick();
      b++;
    end
    chk({tag, "_valid_lo"}, res_valid, 1);
    chk({tag, "_byte_lo"}, res_byte, int'(exp[7:0]));
    for (int k = 0; k < stall; k++) begin
      tick();
      chk({tag, "_stall_byte"}, res_byte, int'(exp[7:0]));
      chk({tag, "_stall_valid"}, res_valid, 1);
    end
    res_ready = 1'b1;
    tick();
    chk({tag, "_valid_hi"}, res_valid, 1);
    chk({tag, "_byte_hi"}, res_byte, int'(exp[15:8]));
    tick();
    res_ready = 1'b0;
    chk({tag, "_idle"}, busy, 0);
    chk({tag, "_count0"}, count, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, nv;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_load_ready", load_ready, 1);
    chk("rst_count", count, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_mac_valid", mac_valid, 0);
    rst_n = 1'b1;
    tick();

    // Mixed signs: 6 + -4 + 49 = 51
    load(8'h32);
    load(8'h4F);
    load(8'h77);
    chk("mixed_count", count, 3);
    do_start();
    lat = 1;
    while (!res_valid && lat < 100) begin
      tick();
      lat++;
    end
    chk("mixed_latency", lat, 6);
    run_expect("mixed", 16'h0033, 0);

    // Negative sum clamps to zero
    load(8'h78);
    do_start();
    run_expect("neg", 16'h0000, 0);

    // Full buffer with an overflow load: 16 * 49 = 784
    for (int k = 0; k < 16; k++) load(8'h77);
    chk("full_count", count, 16);
    chk("full_ready", load_ready, 0);
    load(8'h11);
    chk("full_drop_count", count, 16);
    do_start();
    run_expect("full", 16'h0310, 0);

    // Empty run: no accumulate cycles at all
    nv = n_valid;
    do_start();
    run_expect("empty", 16'h0000, 0);
    chk("empty_no_valid", n_valid, nv);

    // Load with start in the same cycle, plus result backpressure: 30 - 6 = 24
    load(8'h65);
    load_valid = 1'b1;
    load_data  = 8'hD2;
    start      = 1'b1;
    tick();
    load_valid = 1'b0;
    start      = 1'b0;
    chk("simul_count", count, 2);
    run_expect("simul", 16'h0018, 5);

    // Reset in the third stream cycle
    for (int k = 0; k < 5; k++) load(8'h11);
    do_start();
    tick();
    tick();
    tick();
    chk("rst_mid_streaming", mac_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_count", count, 0);
    chk("rst_mid_load_ready", load_ready, 1);
    chk("rst_mid_mac_valid", mac_valid, 0);
    chk("rst_mid_mac_i", mac_i, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    load(8'h33);
    load(8'hEE);
    do_start();
    run_expect("post_rst", 16'h000D, 0);

    // Randomised runs checked by the per-cycle compare
    for (int it = 0; it < 30; it++) begin
      int nl, b;
      bit started;
      started = 1'b0;
      nl = $urandom_range(0, 18);
      for (int k = 0; k < nl; k++) begin
        if ($urandom_range(0, 3) == 0) tick();
        load_valid = 1'b1;
        load_data  = 8'($urandom);
        if (k == nl - 1 && $urandom_range(0, 2) == 0) begin
          start   = 1'b1;
          started = 1'b1;
        end
        tick();
        load_valid = 1'b0;
        start      = 1'b0;
      end
      if (!started) do_start();
      b = 0;
      while (m_run != 0 && b < 300) begin
        res_ready  = 1'($urandom_range(0, 1));
        start      = ($urandom_range(0, 3) == 0);
        load_valid = ($urandom_range(0, 2) == 0);
        load_data  = 8'($urandom);
        tick();
        b++;
      end
      res_ready  = 1'b0;
      start      = 1'b0;
      load_valid = 1'b0;
      chk("rand_run_done", m_run, 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mlp_feeder.md
Name: mlp_feeder

Overview:
- Producer-side sequencer for the MAC/ReLU neuron datapath.
- Buffers up to DEPTH signed 4-bit (input, weight) pairs loaded over a byte port.
- On start, clears the neuron accumulator and streams one pair per cycle into it.
- Captures the 16-bit ReLU result and returns it to the host as two bytes over a valid/ready port, low byte first.

Parameters:
- DEPTH, 16, number of pair slots in the buffer; power of two, minimum 2.
- AW, $clog2(DEPTH), buffer address width. Derived; do not override.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- load_valid  in  1  host offers a pair
- load_data  in  8  {w[3:0], i[3:0]}, both two's complement
- load_ready  out  1  buffer accepts a pair this cycle
- start  in  1  single-cycle pulse that begins a run
- busy  out  1  high in every state except IDLE
- count  out  AW+1  number of pairs currently buffered
- mac_clear  out  1  zeroes the neuron accumulator
- mac_valid  out  1  mac_i/mac_w are live; the accumulator adds i*w
- mac_i  out  4  input operand
- mac_w  out  4  weight operand
- mac_relu  in  16  ReLU of the accumulator register; reflects pairs up to the previous cycle
- res_valid  out  1  res_byte is valid
- res_byte  out  8  result byte
- res_ready  in  1  host consumes res_byte

Behaviour:
- Reset (async assert, sync deassert): state=IDLE, count=0, rd_ptr=0, result=0. All outputs 0 except load_ready=1. Buffer storage is not reset.
- States: IDLE -> CLEAR -> STREAM -> CAPTURE -> OUT_LO -> OUT_HI -> IDLE.
- IDLE:
  - load_ready = (count < DEPTH). A pair is accepted when load_valid && load_ready: it is written at slot count, and count increments.
  - A load offered while count==DEPTH is dropped; count is unchanged.
  - When start is seen, go to CLEAR. If load and start arrive together, the load is accepted first and the run includes that pair.
- CLEAR: one cycle; mac_clear=1, rd_ptr=0. Next state is STREAM if count>0, else CAPTURE.
- STREAM:
  - mac_valid=1; mac_i/mac_w = buffer[rd_ptr]; rd_ptr increments each cycle.
  - Lasts exactly count cycles, then CAPTURE.
  - mac_i/mac_w are 0 whenever mac_valid=0.
- CAPTURE: one cycle; result <= mac_relu. Next state OUT_LO.
- OUT_LO: res_valid=1, res_byte=result[7:0]. Leave on res_valid && res_ready.
- OUT_HI: res_valid=1, res_byte=result[15:8]. On the handshake, count <= 0 and state <= IDLE.
- res_byte is held stable while res_valid=1 and res_ready=0.
- Latency: with start sampled at edge 0 and N pairs buffered, CLEAR runs in cycle 1, STREAM in cycles 2..N+1, CAPTURE in cycle N+2, and the first res_valid appears in cycle N+3.
- load_ready=0 and start is ignored in every non-IDLE state.
- The buffer is read in load order with no wrap; rd_ptr never exceeds count-1.
- Asserting rst_n mid-run aborts the run immediately; the accumulator is cleared by its owner's reset.
- Width rule: mac_relu is non-negative by definition. The block does not reinterpret it; the 16 bits are passed through unchanged.

Decomposition:
- Package mlp_pkg holds:
  - typedef pair_t {logic [3:0] w; logic [3:0] i;}
  - the state enum feeder_state_t
  - constant MLP_ACC_W = 16
- One natural sub-module, mlp_pair_buf: DEPTH x 8 register array with one write port and one combinational read port, no reset.
- FSM, counters and output mux stay in mlp_feeder.

Test Plan:
- Bench model: behavioural accumulator (clear, add sign-extended i*w on valid, output ReLU of the register).
- Mixed signs: load (i=2,w=3), (i=-1,w=4), (i=7,w=7), then start -> sum 51; res_byte 0x33 then 0x00; first res_valid exactly 6 cycles after start; count returns to 0.
- Negative sum: load (i=-8,w=7), start -> accumulator -56, ReLU 0; bytes 0x00, 0x00.
- Full buffer: 16 loads of (7,7) -> load_ready drops once count=16; a 17th offered load is dropped; run yields 784 = 0x0310, bytes 0x10, 0x03.
- Empty run: start with count=0 -> CLEAR, CAPTURE, no mac_valid pulse; bytes 0x00, 0x00.
- Backpressure and simultaneity: hold res_ready=0 for 5 cycles in OUT_LO -> res_byte stays stable. Same-cycle load+start in IDLE -> that pair is included in the stream.
- Reset mid-STREAM: drop rst_n in the 3rd STREAM cycle -> outputs go to reset values immediately, count=0, load_ready=1; a fresh run afterwards produces correct results.
